// File: rtl/shift_add_multiplier.sv
// 8x8 unsigned shift-add multiplier with BCD conversion
// and 7-segment scan output for a 1+4 digit display.
module shift_add_multiplier #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 10
) (
    input  logic               clk_10kHz,
    input  logic               clrn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               load_a,
    input  logic               load_b,
    output logic [2*WIDTH-1:0] p,
    output logic               done,
    output logic [19:0]        p_BCD,
    output logic [3:0]         scan_data_1,
    output logic               scan_en_1,
    output logic [3:0]         scan_data_0,
    output logic [3:0]         scan_en_0,
    output logic [6:0]         data_1_7seg,
    output logic [6:0]         data_0_7seg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
    localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);
    localparam int DW = 20 + 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   reg_a;
    logic [WIDTH-1:0]   reg_b;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               start_q;
    logic               start_edge;
    logic               go;
    logic               finish;
    logic [PW-1:0]      prescale;
    logic [1:0]         idx;
    logic [DW-1:0]      dd;

    assign start_edge = start & ~start_q;
    assign go         = (state != RUN) && start_edge;
    assign finish     = (state == RUN) && (cnt == LAST_CNT);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // FSM state register
    always_ff @(posedge clk_10kHz) begin
        if (clrn) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state: start edges are only honoured outside RUN
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_edge) state_nxt = RUN;
            RUN:     if (finish)     state_nxt = DONE;
            DONE:    if (start_edge) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers, start edge detect and shift-add datapath
    always_ff @(posedge clk_10kHz) begin
        if (clrn) begin
            reg_a   <= '0;
            reg_b   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            p       <= '0;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (load_a) reg_a <= a;
            if (load_b) reg_b <= b;
            if (go) begin
                mcand  <= {{WIDTH{1'b0}}, reg_a};
                mplier <= reg_b;
                acc    <= '0;
                cnt    <= '0;
                done   <= 1'b0;
            end else if (finish) begin
                p    <= acc;
                done <= 1'b1;
            end else if (state == RUN) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    // Double-dabble binary to BCD of the product register
    always_comb begin
        dd = {20'b0, p};
        for (int i = 0; i < 2 * WIDTH; i++) begin
            for (int d = 0; d < 5; d++) begin
                if (dd[2*WIDTH+4*d +: 4] >= 4'd5)
                    dd[2*WIDTH+4*d +: 4] = dd[2*WIDTH+4*d +: 4] + 4'd3;
            end
            dd = dd << 1;
        end
        p_BCD = dd[DW-1 -: 20];
    end

    // Display-0 prescaler and digit index; display-1 enable
    always_ff @(posedge clk_10kHz) begin
        if (clrn) begin
            prescale  <= '0;
            idx       <= '0;
            scan_en_1 <= 1'b0;
        end else begin
            scan_en_1 <= 1'b1;
            if (prescale == LAST_PRE) begin
                prescale <= '0;
                idx      <= idx + 1'b1;
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    assign scan_en_0   = 4'b0001 << idx;
    assign scan_data_0 = p_BCD[{idx, 2'b00} +: 4];
    assign scan_data_1 = p_BCD[19:16];
    assign data_0_7seg = seg7(scan_data_0);
    assign data_1_7seg = seg7(scan_data_1);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed testbench for shift_add_multiplier: reset, products,
// start-edge rules, mid-run reset and display scanning.
module tb_shift_add_multiplier;

    logic        clk_10kHz = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic [15:0] p;
    logic        done;
    logic [19:0] p_BCD;
    logic [3:0]  scan_data_1;
    logic        scan_en_1;
    logic [3:0]  scan_data_0;
    logic [3:0]  scan_en_0;
    logic [6:0]  data_1_7seg;
    logic [6:0]  data_0_7seg;

    int checks = 0;
    int passes = 0;
    int n;

    shift_add_multiplier #(.WIDTH(8), .SCAN_DIV(10)) dut (
        .clk_10kHz   (clk_10kHz),
        .clrn        (clrn),
        .start       (start),
        .a           (a),
        .b           (b),
        .load_a      (load_a),
        .load_b      (load_b),
        .p           (p),
        .done        (done),
        .p_BCD       (p_BCD),
        .scan_data_1 (scan_data_1),
        .scan_en_1   (scan_en_1),
        .scan_data_0 (scan_data_0),
        .scan_en_0   (scan_en_0),
        .data_1_7seg (data_1_7seg),
        .data_0_7seg (data_0_7seg)
    );

    always #5 clk_10kHz = ~clk_10kHz;

    task automatic tick();
        @(posedge clk_10kHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [7:0] x, input logic [7:0] y);
        a = x; b = y; load_a = 1'b1; load_b = 1'b1;
        tick();
        load_a = 1'b0; load_b = 1'b0; a = '0; b = '0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic mult(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input string tag);
        int lat;
        load(x, y);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_p"}, p, exp);
    endtask

    initial begin
        logic [3:0] exp_en [4];
        logic [3:0] exp_d [4];
        logic [6:0] exp_s [4];
        exp_en = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_d  = '{4'd6, 4'd8, 4'd1, 4'd0};
        exp_s  = '{7'h7D, 7'h7F, 7'h06, 7'h3F};

        clrn = 1'b1;
        tick();
        check("rst_p", p, 0);
        check("rst_done", done, 0);
        check("rst_bcd", p_BCD, 0);
        check("rst_en0", scan_en_0, 4'b0001);
        check("rst_seg0", data_0_7seg, 7'h3F);
        check("rst_seg1", data_1_7seg, 7'h3F);
        clrn = 1'b0;
        tick();
        check("en1_out_of_reset", scan_en_1, 1);

        load(8'd62, 8'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p_held_in_run", p, 0);
        wait_done(n);
        check("basic_latency", n, 9);
        check("basic_p", p, 16'd186);
        check("basic_bcd", p_BCD, 20'h00186);

        n = 0;
        while (scan_en_0 !== 4'b1000 && n < 60) begin tick(); n++; end
        while (scan_en_0 !== 4'b0001 && n < 60) begin tick(); n++; end
        check("scan_sync", n < 60, 1);
        for (int k = 0; k < 4; k++) begin
            check("scan_en_first", scan_en_0, exp_en[k]);
            check("scan_data", scan_data_0, exp_d[k]);
            check("scan_seg", data_0_7seg, exp_s[k]);
            repeat (9) tick();
            check("scan_en_last", scan_en_0, exp_en[k]);
            tick();
        end
        check("scan_wrap", scan_en_0, 4'b0001);

        mult(8'd255, 8'd255, 16'd65025, "max");
        check("max_bcd", p_BCD, 20'h65025);
        check("max_d1", scan_data_1, 4'd6);
        check("max_seg1", data_1_7seg, 7'h7D);

        mult(8'd0, 8'd77, 16'd0, "zero");
        check("zero_done", done, 1);

        load(8'd3, 8'd5);
        start = 1'b1;
        repeat (5) tick();
        check("held_run", done, 0);
        repeat (10) tick();
        check("held_done", done, 1);
        check("held_p", p, 16'd15);
        start = 1'b0;
        tick();
        check("held_still_done", done, 1);

        load(8'd200, 8'd9);
        tick();
        check("post_load_p", p, 16'd15);
        check("post_load_done", done, 1);

        load(8'd10, 8'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        check("restart_ignored_lat", n, 9);
        check("restart_ignored_p", p, 16'd100);

        load(8'd7, 8'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clrn = 1'b1;
        tick();
        clrn = 1'b0;
        check("midrst_p", p, 0);
        check("midrst_done", done, 0);
        repeat (12) tick();
        check("midrst_no_finish", done, 0);
        mult(8'd125, 8'd2, 16'd250, "after_rst");
        check("after_rst_bcd", p_BCD, 20'h00250);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
